gray_count_sequencer: RTL and testbench

- Mode controller that drives the clock-enable and clear of the N-bit Gray counter.
- Converts debounced button pulses into single-step, free-run and fixed-length burst counting.
- Sits between the button pulse generators and the counter's clk_en input.
- Also exports its mode so the display or LEDs can show it.

---
 rtl/gray_count_sequencer_pkg.sv | 29 ++
 rtl/gray_tick_prescaler.sv | 38 +++
 rtl/gray_count_sequencer.sv | 120 ++++++++++++
 tb/tb_gray_count_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_count_sequencer_pkg.sv
// Shared state encodings, rate-select shift factor and counter-width helpers
// for the Gray counter mode sequencer.
package gray_count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BURST = 2'd3
  } seq_state_t;

  // Each rate_sel step multiplies the tick period by 1 << RATE_SHIFT.
  localparam int RATE_SHIFT = 2;

  function automatic int width_for(input longint unsigned max_val);
    int w;
    w = 1;
    for (int i = 1; i < 64; i++) begin
      if (max_val >= (64'd1 << i)) w = i + 1;
    end
    return w;
  endfunction

  // Slowest rate_sel gives a period of 64*BASE_DIV, so the prescaler must hold 64*BASE_DIV-1.
  function automatic int prescale_width(input longint unsigned base_div);
    return width_for((base_div << (3 * RATE_SHIFT)) - 1);
  endfunction

endpackage

// File: rtl/gray_tick_prescaler.sv
// Free-running tick prescaler; period BASE_DIV << (RATE_SHIFT*rate_sel), combinational tick.
// Latency: tick is asserted in the cycle the count reaches period-1; no backpressure.
module gray_tick_prescaler
  import gray_count_sequencer_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 50_000_000,
  parameter int          PRESCALE_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  input  logic [1:0] rate_sel,
  output logic       tick
);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] period_m1;
  logic [2:0]            shamt;
  logic                  due;

  assign shamt     = 3'(RATE_SHIFT) * 3'(rate_sel);
  assign period_m1 = (PRESCALE_W'(BASE_DIV) << shamt) - PRESCALE_W'(1);
  // >= rather than == so a shorter period selected mid-count fires at once.
  assign due       = (cnt >= period_m1);
  assign tick      = run & due;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= due ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/gray_count_sequencer.sv
// Mode sequencer (STOP/STEP/RUN/BURST) driving the Gray counter's enable and clear.
// Outputs registered, one cycle after the sampled pulse/tick; idle return to STOP under GRAY_SEQ_IDLE_TIMEOUT_EN.
module gray_count_sequencer
  import gray_count_sequencer_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 50_000_000,
  parameter int          PRESCALE_W = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int          BURST_W    = 8,
  parameter int unsigned TIMEOUT    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_pulse,
  input  logic       step_pulse,
  input  logic [1:0] rate_sel,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] mode,
  output logic       busy
);

  seq_state_t         state, state_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               en_nxt, clr_nxt;
  logic               tick, presc_clear, presc_run;
  logic               timeout_hit;

  assign presc_run   = (state == ST_RUN) || (state == ST_BURST);
  assign presc_clear = (state_nxt != state);

  gray_tick_prescaler #(
    .BASE_DIV   (BASE_DIV),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (presc_clear),
    .run      (presc_run),
    .rate_sel (rate_sel),
    .tick     (tick)
  );

`ifdef GRAY_SEQ_IDLE_TIMEOUT_EN
  localparam int IDLE_W = width_for(TIMEOUT);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != ST_STEP || state_nxt != ST_STEP || step_pulse) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // mode_pulse always takes priority, so a coincident step or due tick is dropped.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    en_nxt        = 1'b0;
    clr_nxt       = 1'b0;
    case (state)
      ST_STOP: begin
        if (mode_pulse)      state_nxt = ST_STEP;
        else if (step_pulse) clr_nxt   = 1'b1;
      end
      ST_STEP: begin
        if (mode_pulse)       state_nxt = ST_RUN;
        else if (step_pulse)  en_nxt    = 1'b1;
        else if (timeout_hit) state_nxt = ST_STOP;
      end
      ST_RUN: begin
        if (mode_pulse) begin
          state_nxt     = ST_BURST;
          burst_cnt_nxt = '0;
        end else if (tick) begin
          en_nxt = 1'b1;
        end
      end
      ST_BURST: begin
        if (mode_pulse) begin
          state_nxt = ST_STOP;
        end else if (tick) begin
          en_nxt        = 1'b1;
          burst_cnt_nxt = burst_cnt + BURST_W'(1);
          if (burst_cnt_nxt == BURST_W'(BURST_LEN)) state_nxt = ST_STEP;
        end
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_STOP;
      burst_cnt <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      cnt_en    <= en_nxt;
      cnt_clr   <= clr_nxt;
      busy      <= (state_nxt == ST_RUN) || (state_nxt == ST_BURST);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Directed bench for gray_count_sequencer with BASE_DIV=4, BURST_LEN=3, TIMEOUT=20.
module tb_gray_count_sequencer;

  logic       clk;
  logic       rst;
  logic       mode_pulse;
  logic       step_pulse;
  logic [1:0] rate_sel;
  logic       cnt_en;
  logic       cnt_clr;
  logic [1:0] mode;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  gray_count_sequencer #(
    .BASE_DIV   (4),
    .PRESCALE_W (32),
    .BURST_LEN  (3),
    .BURST_W    (8),
    .TIMEOUT    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_pulse (mode_pulse),
    .step_pulse (step_pulse),
    .rate_sel   (rate_sel),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .mode       (mode),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e, input logic c,
                          input logic [1:0] m, input logic b);
    chk({tag, ".cnt_en"}, 32'(cnt_en), 32'(e));
    chk({tag, ".cnt_clr"}, 32'(cnt_clr), 32'(c));
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic pulse_mode();
    mode_pulse = 1'b1;
    cyc();
    mode_pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    mode_pulse = 1'b0;
    step_pulse = 1'b0;
    rate_sel   = 2'd0;

    repeat (3) begin cyc(); chk_outs("reset_hold", 0, 0, 0, 0); end
    rst = 1'b1;
    repeat (3) begin cyc(); chk_outs("after_release", 0, 0, 0, 0); end

    // STEP: three single-cycle enables, one cycle after each pulse
    pulse_mode();
    chk_outs("enter_step", 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step_pulse = 1'b1;
      cyc();
      step_pulse = 1'b0;
      chk_outs("step_en", 1, 0, 1, 0);
      repeat (4) begin cyc(); chk_outs("step_gap", 0, 0, 1, 0); end
    end

    // RUN at rate_sel=0 then 1
    rate_sel = 2'd0;
    pulse_mode();
    chk_outs("enter_run", 0, 0, 2, 1);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk("run_r0_en", 32'(cnt_en), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    rate_sel = 2'd1;
    for (int i = 41; i <= 72; i++) begin
      cyc();
      chk("run_r1_en", 32'(cnt_en), (i == 56 || i == 72) ? 32'd1 : 32'd0);
    end

    // BURST: three enables four apart, then back to STEP
    rate_sel = 2'd0;
    pulse_mode();
    chk_outs("enter_burst", 0, 0, 3, 1);
    for (int j = 1; j <= 14; j++) begin
      cyc();
      chk("burst_en", 32'(cnt_en), (j % 4 == 0 && j <= 12) ? 32'd1 : 32'd0);
      chk("burst_mode", 32'(mode), (j < 12) ? 32'd3 : 32'd1);
      chk("burst_busy", 32'(busy), (j < 12) ? 32'd1 : 32'd0);
    end

    // BURST aborted after the first enable
    pulse_mode();
    chk("abort_run_mode", 32'(mode), 32'd2);
    pulse_mode();
    chk("abort_burst_mode", 32'(mode), 32'd3);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      chk("abort_first_en", 32'(cnt_en), (j == 4) ? 32'd1 : 32'd0);
    end
    pulse_mode();
    chk_outs("abort", 0, 0, 0, 0);
    repeat (12) begin cyc(); chk_outs("abort_quiet", 0, 0, 0, 0); end

    // STOP clear, then coincident mode and step pulses
    step_pulse = 1'b1;
    cyc();
    step_pulse = 1'b0;
    chk_outs("stop_clr", 0, 1, 0, 0);
    cyc();
    chk_outs("stop_clr_end", 0, 0, 0, 0);
    mode_pulse = 1'b1;
    step_pulse = 1'b1;
    cyc();
    mode_pulse = 1'b0;
    step_pulse = 1'b0;
    chk_outs("both_pulses", 0, 0, 1, 0);
    cyc();
    chk_outs("both_pulses_next", 0, 0, 1, 0);

    // leaving RUN on the cycle its tick is due drops that tick
    pulse_mode();
    repeat (3) begin cyc(); chk("run_pre_tick", 32'(cnt_en), 32'd0); end
    pulse_mode();
    chk_outs("run_exit_drop", 0, 0, 3, 1);
    for (int j = 1; j <= 12; j++) begin
      cyc();
      chk("burst2_en", 32'(cnt_en), (j % 4 == 0) ? 32'd1 : 32'd0);
      chk("burst2_mode", 32'(mode), (j < 12) ? 32'd3 : 32'd1);
    end

    // shorter period selected mid-count fires on the next edge
    rate_sel = 2'd1;
    pulse_mode();
    repeat (10) begin cyc(); chk("slow_count", 32'(cnt_en), 32'd0); end
    rate_sel = 2'd0;
    cyc();
    chk("rate_shrink_en", 32'(cnt_en), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      chk("rate_shrink_next", 32'(cnt_en), (j == 4) ? 32'd1 : 32'd0);
    end

    // asynchronous reset in the middle of a burst
    pulse_mode();
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0, 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk_outs("post_async_reset", 0, 0, 0, 0);

    // idle behaviour in STEP
    pulse_mode();
    chk("idle_enter", 32'(mode), 32'd1);
`ifdef GRAY_SEQ_IDLE_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("idle_timeout_mode", 32'(mode), (k < 20) ? 32'd1 : 32'd0);
    end
    pulse_mode();
    repeat (14) cyc();
    step_pulse = 1'b1;
    cyc();
    step_pulse = 1'b0;
    chk_outs("idle_step_en", 1, 0, 1, 0);
    for (int k = 16; k <= 35; k++) begin
      cyc();
      chk("idle_defer_mode", 32'(mode), (k < 35) ? 32'd1 : 32'd0);
    end
`else
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk_outs("idle_persist", 0, 0, 1, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
